// File: rtl/expand_vector_alu.sv
// rtl/expand_vector_alu.sv - scalar-to-vector expander (broadcast/ramp/shift/zero); option macro EXPAND_SATURATE_EN
module expand_vector_alu #(
   parameter int BITS = 8,
   parameter int N    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BITS-1:0]      in,
   input  logic [BITS-1:0]      step,
   input  logic [$clog2(N):0]   out_len,
   input  logic [1:0]           sel,
   input  logic                 set,
   input  logic                 en,
   output logic [BITS-1:0]      out [N-1:0],
   output logic                 busy,
   output logic                 done
);

   localparam int LW = $clog2(N) + 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [BITS-1:0] r_acc, r_step, w_acc_next, w_lane;
   logic [BITS:0]   w_sum;
   logic [1:0]      r_sel;
   logic [LW-1:0]   r_len, r_idx, w_len;
   logic [BITS-1:0] r_out [N-1:0];
   logic            w_start, w_adv, w_last;

   always_comb begin
      w_len   = (out_len > LW'(N)) ? LW'(N) : out_len;
      w_start = set && (r_state != S_FILL);
      w_adv   = (r_state == S_FILL) && en;
      w_last  = ((r_idx + LW'(1)) == r_len);
      w_lane  = (r_sel == 2'b11) ? '0 : r_acc;
      w_sum   = {1'b0, r_acc} + {1'b0, r_step};

      w_acc_next = r_acc;
      case (r_sel)
         2'b01: begin
`ifdef EXPAND_SATURATE_EN
            w_acc_next = w_sum[BITS] ? '1 : w_sum[BITS-1:0];
`else
            w_acc_next = w_sum[BITS-1:0];
`endif
         end
         2'b10: begin
`ifdef EXPAND_SATURATE_EN
            // a set MSB would be shifted out, so the lane pins at full scale
            w_acc_next = r_acc[BITS-1] ? '1 : (r_acc << 1);
`else
            w_acc_next = r_acc << 1;
`endif
         end
         default: w_acc_next = r_acc;
      endcase

      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (set) w_next = (w_len == '0) ? S_DONE : S_FILL;
         S_FILL:         if (en && w_last) w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_step  <= '0;
         r_sel   <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         for (int k = 0; k < N; k++) r_out[k] <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_acc  <= in;
            r_step <= step;
            r_sel  <= sel;
            r_len  <= w_len;
            r_idx  <= '0;
            for (int k = 0; k < N; k++) r_out[k] <= '0;
         end else if (w_adv) begin
            for (int k = 0; k < N; k++)
               if (r_idx == LW'(k)) r_out[k] <= w_lane;
            r_idx <= r_idx + LW'(1);
            r_acc <= w_acc_next;
         end
      end
   end

   assign out  = r_out;
   assign busy = (r_state == S_FILL);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_expand_vector_alu.sv
// tb/tb_expand_vector_alu.sv - self-checking bench for expand_vector_alu
module tb_expand_vector_alu;

   logic       clk = 1'b0;
   logic       rst, set, en;
   logic [7:0] in, step;
   logic [3:0] out_len;
   logic [1:0] sel;
   logic [7:0] out [7:0];
   logic       busy, done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   expand_vector_alu #(.BITS(8), .N(8)) dut (
      .clk(clk), .rst(rst), .in(in), .step(step), .out_len(out_len),
      .sel(sel), .set(set), .en(en), .out(out), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [1:0]      sel;
      logic [7:0]      a;
      logic [7:0]      b;
      logic [3:0]      len;
      logic [7:0][7:0] lanes;
      int              cyc;
      int              bcnt;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model_lane(input logic [1:0] s, input logic [7:0] a,
                                             input logic [7:0] b, input int k, input int len);
      longint v;
      if (k >= len) return 8'd0;
      case (s)
         2'd0:    v = longint'(a);
         2'd1:    v = longint'(a) + longint'(k) * longint'(b);
         2'd2:    v = longint'(a) * (longint'(1) << k);
         default: v = 0;
      endcase
`ifdef EXPAND_SATURATE_EN
      if (v > 255) v = 255;
`endif
      return v[7:0];
   endfunction

   task automatic do_fill(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] l, output int cyc, output int bcnt);
      sel = s; in = a; step = b; out_len = l; en = 1'b1; set = 1'b1;
      @(posedge clk); #1;
      set = 1'b0;
      cyc = 1;
      bcnt = busy ? 1 : 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int cyc, bcnt, len;
      logic [1:0] rs;
      logic [7:0] ra, rb;
      logic [3:0] rl;

      rst = 1'b1; set = 1'b0; en = 1'b0; in = 8'd0; step = 8'd0; out_len = 4'd0; sel = 2'd0;

      tbl[0] = '{2'd1, 8'd3, 8'd2, 4'd4,
                 {8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd7, 8'd5, 8'd3}, 5, 4};
      tbl[1] = '{2'd0, 8'h5A, 8'd0, 4'd12,
                 {8{8'h5A}}, 9, 8};
      tbl[2] = '{2'd1, 8'd7, 8'd1, 4'd0,
                 {8{8'h00}}, 1, 0};
`ifdef EXPAND_SATURATE_EN
      tbl[3] = '{2'd1, 8'd250, 8'd3, 4'd3,
                 {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd253, 8'd250}, 4, 3};
      tbl[4] = '{2'd2, 8'h41, 8'd0, 4'd3,
                 {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h82, 8'h41}, 4, 3};
`else
      tbl[3] = '{2'd1, 8'd250, 8'd3, 4'd3,
                 {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd253, 8'd250}, 4, 3};
      tbl[4] = '{2'd2, 8'h41, 8'd0, 4'd3,
                 {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h82, 8'h41}, 4, 3};
`endif
      tbl[5] = '{2'd3, 8'hAA, 8'd5, 4'd5,
                 {8{8'h00}}, 6, 5};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("reset_lane%0d", k), out[k], 0);
      rst = 1'b0;

      for (int t = 0; t < 6; t++) begin
         do_fill(tbl[t].sel, tbl[t].a, tbl[t].b, tbl[t].len, cyc, bcnt);
         chk($sformatf("tbl%0d_done_cycles", t), cyc, tbl[t].cyc);
         chk($sformatf("tbl%0d_busy_cycles", t), bcnt, tbl[t].bcnt);
         for (int k = 0; k < 8; k++)
            chk($sformatf("tbl%0d_lane%0d", t, k), out[k], tbl[t].lanes[k]);
      end

      for (int r = 0; r < 20; r++) begin
         rs = 2'($urandom_range(0, 3));
         ra = 8'($urandom);
         rb = 8'($urandom);
         rl = 4'($urandom_range(0, 15));
         len = (rl > 8) ? 8 : int'(rl);
         do_fill(rs, ra, rb, rl, cyc, bcnt);
         chk($sformatf("rand%0d_done_cycles", r), cyc, len + 1);
         chk($sformatf("rand%0d_busy_cycles", r), bcnt, len);
         for (int k = 0; k < 8; k++)
            chk($sformatf("rand%0d_lane%0d", r, k), out[k], model_lane(rs, ra, rb, k, len));
      end

      // stall two cycles after lane 1, with an ignored set pulse during the stall
      sel = 2'd1; in = 8'd1; step = 8'd1; out_len = 4'd4; en = 1'b1; set = 1'b1;
      @(posedge clk); #1; set = 1'b0; cyc = 1;
      @(posedge clk); #1; cyc++;
      @(posedge clk); #1; cyc++;
      en = 1'b0; set = 1'b1; in = 8'd9;
      @(posedge clk); #1; cyc++; set = 1'b0;
      @(posedge clk); #1; cyc++;
      chk("stall_busy", busy, 1);
      chk("stall_lane2", out[2], 0);
      en = 1'b1;
      while (!done && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      chk("stall_done_cycles", cyc, 7);
      for (int k = 0; k < 8; k++)
         chk($sformatf("stall_lane%0d", k), out[k], (k < 4) ? k + 1 : 0);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done", done, 1);
      chk("hold_lane3", out[3], 4);

      // reset during the third FILL cycle
      sel = 2'd1; in = 8'd10; step = 8'd1; out_len = 4'd8; en = 1'b1; set = 1'b1;
      @(posedge clk); #1; set = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("abort_lane%0d", k), out[k], 0);
      do_fill(2'd1, 8'd20, 8'd4, 4'd6, cyc, bcnt);
      chk("refill_done_cycles", cyc, 7);
      for (int k = 0; k < 8; k++)
         chk($sformatf("refill_lane%0d", k), out[k], model_lane(2'd1, 8'd20, 8'd4, k, 6));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/expand_vector_alu.md
EXPAND_VECTOR_ALU -- requirements
Module: expand_vector_alu

Interface
REQ-001 Parameter BITS, default 8, element width in bits.
REQ-002 Parameter N, default 8, number of output vector lanes.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in  input  BITS  scalar seed value.
REQ-007 step  input  BITS  ramp increment.
REQ-008 out_len  input  $clog2(N)+1  number of lanes to fill.
REQ-009 sel  input  2  fill mode: 00 broadcast, 01 ramp, 10 shift-left, 11 zero.
REQ-010 set  input  1  start pulse.
REQ-011 en  input  1  advance enable; low stalls the fill.
REQ-012 out  output  BITS x N (unpacked array [N-1:0])  expanded vector.
REQ-013 busy  output  1  high while filling.
REQ-014 done  output  1  high when the fill is complete.

Function
REQ-015 FSM states IDLE, FILL, DONE; reset state IDLE.
REQ-016 set=1 in IDLE or DONE: latch in, step, sel; latch len = min(out_len, N); clear all out lanes to 0; clear done; index i = 0; accumulator = in; go to FILL, or to DONE if len = 0.
REQ-017 set=1 in FILL is ignored.
REQ-018 In FILL with en=1: write out[i] = accumulator, i = i+1, then update the accumulator per mode.
REQ-019 In FILL with en=0: no state, lane or accumulator change.
REQ-020 Broadcast: accumulator is unchanged, so out[i] = in.
REQ-021 Ramp: out[i] = in + i*step, modulo 2^BITS.
REQ-022 Shift-left: out[i] = in << i, truncated to BITS.
REQ-023 Zero: lanes are written with 0.
REQ-024 After the write to lane len-1, go to DONE on the next edge.
REQ-025 Latency: done rises on the first edge after the len-th en-high FILL cycle; with en held at 1, done is high exactly len+1 cycles after the set edge.
REQ-026 busy = 1 only in FILL; done = 1 only in DONE.
REQ-027 DONE holds with out stable until the next set.
REQ-028 Lanes with index >= len stay 0.

Reset
REQ-029 rst=1 forces IDLE, all out lanes 0, busy 0, done 0, i 0, accumulator 0.
REQ-030 rst has priority over set and en.
REQ-031 rst mid-FILL aborts the fill with no partial lanes retained.

Configuration
REQ-032 Macro EXPAND_SATURATE_EN.
REQ-033 Defined: ramp and shift-left saturate each lane at 2^BITS-1; once saturated, later lanes stay at 2^BITS-1.
REQ-034 Undefined: ramp and shift-left wrap modulo 2^BITS (REQ-021, REQ-022).
REQ-035 Broadcast and zero modes are identical in both builds.

Verification
REQ-036 Ramp, in=3, step=2, out_len=4, en=1 -> out[0..3]=3,5,7,9; out[4..7]=0; done high 5 cycles after the set edge; busy high 4 cycles.
REQ-037 Broadcast, in=0x5A, out_len=12 -> len clamps to 8; all 8 lanes 0x5A; done after 9 cycles.
REQ-038 Ramp in=1, step=1, out_len=4, en low for 2 cycles after lane 1 -> out=1,2,3,4; done delayed by exactly 2 cycles; set pulsed mid-FILL is ignored.
REQ-039 out_len=0 -> done high on the cycle after set; busy never high; all lanes 0.
REQ-040 Ramp in=250, step=3, out_len=3 -> 250,253,0 without EXPAND_SATURATE_EN; 250,253,255 with it. Shift-left in=0x41, out_len=3 -> 0x41,0x82,0x04 wrap; 0x41,0x82,0xFF saturated.
REQ-041 rst asserted during the third FILL cycle -> next cycle all lanes 0, busy 0, done 0; a fresh set then completes normally.
